// File: rtl/tse_ddr_bridge_pkg.sv
// tse_ddr_bridge_pkg: shared FSM encoding and requester ids for the TSE-to-DDR bridge arbiter
package tse_ddr_bridge_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_e;
  localparam logic RID_TSE_RX = 1'b0;
  localparam logic RID_TSE_TX = 1'b1;
endpackage

// File: rtl/tse_ddr_bridge_tag_fifo.sv
// tse_ddr_bridge_tag_fifo: 1-bit register FIFO recording which requester owns each outstanding read
module tse_ddr_bridge_tag_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        din,
  input  logic        pop,
  output logic        dout,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);
  logic [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;
  assign full  = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign dout  = mem_q[rp_q];
  assign count = cnt_q;
  always_comb begin
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    mem_d   = mem_q;
    if (do_push) mem_d[wp_q] = din;
    wp_d  = wp_q + AW'(do_push);
    rp_d  = rp_q + AW'(do_pop);
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/tse_ddr_bridge_arbiter.sv
// tse_ddr_bridge_arbiter: round-robin share of the bridge slave port between TSE RX-write and TX-read masters,
// with in-order read responses steered back through a tag FIFO.
module tse_ddr_bridge_arbiter
  import tse_ddr_bridge_pkg::*;
#(
  parameter int ADDR_W    = 23,
  parameter int DATA_W    = 32,
  parameter int BE_W      = 4,
  parameter int TAG_DEPTH = 16,
  parameter int TAG_AW    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] r0_address,
  input  logic [BE_W-1:0]   r0_byteenable,
  input  logic              r0_read,
  input  logic              r0_write,
  input  logic [DATA_W-1:0] r0_writedata,
  output logic              r0_waitrequest,
  output logic [DATA_W-1:0] r0_readdata,
  output logic              r0_readdatavalid,
  output logic              r0_endofpacket,
  input  logic [ADDR_W-1:0] r1_address,
  input  logic [BE_W-1:0]   r1_byteenable,
  input  logic              r1_read,
  input  logic              r1_write,
  input  logic [DATA_W-1:0] r1_writedata,
  output logic              r1_waitrequest,
  output logic [DATA_W-1:0] r1_readdata,
  output logic              r1_readdatavalid,
  output logic              r1_endofpacket,
  output logic [ADDR_W-1:0] d_address,
  output logic [BE_W-1:0]   d_byteenable,
  output logic              d_read,
  output logic              d_write,
  output logic [DATA_W-1:0] d_writedata,
  input  logic              d_waitrequest,
  input  logic [DATA_W-1:0] d_readdata,
  input  logic              d_readdatavalid,
  input  logic              d_endofpacket,
  output logic              rsp_error
);
  state_e          state_q, state_d;
  logic            last_q, last_d, rsp_error_q, rsp_error_d;
  logic            e0, e1, blk, gv, gid, greq, g_read, g_write, acc;
  logic            tag_push, tag_full, tag_empty, tag_head;
  logic [TAG_AW:0] tag_count;

  // registered count only: a same-cycle pop must not unblock a read
  assign blk = tag_count == (TAG_AW+1)'(TAG_DEPTH);

  always_comb begin
    e0       = (r0_read | r0_write) & ~(r0_read & blk);
    e1       = (r1_read | r1_write) & ~(r1_read & blk);
    gid      = state_q == LOCK0 ? RID_TSE_RX :
               state_q == LOCK1 ? RID_TSE_TX :
               (e0 & e1) ? ~last_q : e1;
    gv       = (state_q != IDLE) | e0 | e1;
    greq     = gid ? (r1_read | r1_write) : (r0_read | r0_write);
    g_read   = gv & (gid ? r1_read : r0_read);
    g_write  = gv & (gid ? r1_write : r0_write);
    acc      = (g_read | g_write) & ~d_waitrequest;
    tag_push = acc & g_read & ~tag_full;
    last_d   = acc ? gid : last_q;
    state_d  = state_q;
    if (state_q == IDLE) begin
      if (gv & d_waitrequest) state_d = gid ? LOCK1 : LOCK0;
    end else if (~greq | ~d_waitrequest) state_d = IDLE;
    rsp_error_d = rsp_error_q | (d_readdatavalid & tag_empty);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      last_q      <= RID_TSE_TX;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  tse_ddr_bridge_tag_fifo #(.DEPTH(TAG_DEPTH), .AW(TAG_AW)) u_tag_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tag_push),
    .din   (gid),
    .pop   (d_readdatavalid),
    .dout  (tag_head),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

  assign d_read         = g_read & ~reset;
  assign d_write        = g_write & ~reset;
  assign d_address      = gid ? r1_address : r0_address;
  assign d_byteenable   = gid ? r1_byteenable : r0_byteenable;
  assign d_writedata    = gid ? r1_writedata : r0_writedata;
  assign r0_waitrequest = reset | ~gv | (gid != RID_TSE_RX) | d_waitrequest;
  assign r1_waitrequest = reset | ~gv | (gid != RID_TSE_TX) | d_waitrequest;
  assign r0_readdatavalid = d_readdatavalid & ~tag_empty & (tag_head == RID_TSE_RX);
  assign r1_readdatavalid = d_readdatavalid & ~tag_empty & (tag_head == RID_TSE_TX);
  assign r0_endofpacket = d_endofpacket & r0_readdatavalid;
  assign r1_endofpacket = d_endofpacket & r1_readdatavalid;
  assign r0_readdata    = d_readdata;
  assign r1_readdata    = d_readdata;
  assign rsp_error      = rsp_error_q;
endmodule

// File: tb/tb_tse_ddr_bridge_arbiter.sv
// tb_tse_ddr_bridge_arbiter: directed scenarios plus randomized traffic against a queue-based reference model
module tb_tse_ddr_bridge_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [22:0] r0_address, r1_address, d_address;
  logic [3:0]  r0_byteenable, r1_byteenable, d_byteenable;
  logic        r0_read, r0_write, r1_read, r1_write;
  logic [31:0] r0_writedata, r1_writedata, r0_readdata, r1_readdata, d_writedata, d_readdata;
  logic        r0_waitrequest, r1_waitrequest, r0_readdatavalid, r1_readdatavalid;
  logic        r0_endofpacket, r1_endofpacket;
  logic        d_read, d_write, d_waitrequest, d_readdatavalid, d_endofpacket, rsp_error;
  logic [8:0]  dut_vec;
  int          checks = 0;
  int          failures = 0;

  bit m_tags[$];
  int m_owner = -1;
  bit m_last = 1'b1;
  bit m_err = 1'b0;

  tse_ddr_bridge_arbiter dut (
    .clk(clk), .reset(reset),
    .r0_address(r0_address), .r0_byteenable(r0_byteenable), .r0_read(r0_read), .r0_write(r0_write),
    .r0_writedata(r0_writedata), .r0_waitrequest(r0_waitrequest), .r0_readdata(r0_readdata),
    .r0_readdatavalid(r0_readdatavalid), .r0_endofpacket(r0_endofpacket),
    .r1_address(r1_address), .r1_byteenable(r1_byteenable), .r1_read(r1_read), .r1_write(r1_write),
    .r1_writedata(r1_writedata), .r1_waitrequest(r1_waitrequest), .r1_readdata(r1_readdata),
    .r1_readdatavalid(r1_readdatavalid), .r1_endofpacket(r1_endofpacket),
    .d_address(d_address), .d_byteenable(d_byteenable), .d_read(d_read), .d_write(d_write),
    .d_writedata(d_writedata), .d_waitrequest(d_waitrequest), .d_readdata(d_readdata),
    .d_readdatavalid(d_readdatavalid), .d_endofpacket(d_endofpacket), .rsp_error(rsp_error)
  );

  always #5 clk = ~clk;

  assign dut_vec = {d_read, d_write, r0_waitrequest, r1_waitrequest, r0_readdatavalid,
                    r1_readdatavalid, r0_endofpacket, r1_endofpacket, rsp_error};

  // who owns the port this cycle: -1 none, else requester id
  function automatic int exp_gnt();
    bit e0, e1, full;
    if (reset) return -1;
    if (m_owner >= 0) return m_owner;
    full = m_tags.size() == 16;
    e0 = (r0_read || r0_write) && !(r0_read && full);
    e1 = (r1_read || r1_write) && !(r1_read && full);
    if (e0 && e1) return m_last ? 0 : 1;
    if (e0) return 0;
    if (e1) return 1;
    return -1;
  endfunction

  function automatic logic [8:0] exp_vec();
    int g;
    bit rd, wr, v0, v1, h;
    g  = exp_gnt();
    rd = (g == 0) ? r0_read : (g == 1) ? r1_read : 1'b0;
    wr = (g == 0) ? r0_write : (g == 1) ? r1_write : 1'b0;
    h  = 1'b0;
    v0 = 1'b0;
    v1 = 1'b0;
    if (m_tags.size() > 0) begin
      h  = m_tags[0];
      v0 = d_readdatavalid && !h;
      v1 = d_readdatavalid && h;
    end
    return {rd, wr, reset || g != 0 || d_waitrequest, reset || g != 1 || d_waitrequest,
            v0, v1, v0 && d_endofpacket, v1 && d_endofpacket, m_err};
  endfunction

  always @(posedge clk or posedge reset) begin : model
    int g;
    bit rd, wr;
    if (reset) begin
      m_tags.delete();
      m_owner = -1;
      m_last  = 1'b1;
      m_err   = 1'b0;
    end else begin
      g  = exp_gnt();
      rd = (g == 0) ? r0_read : (g == 1) ? r1_read : 1'b0;
      wr = (g == 0) ? r0_write : (g == 1) ? r1_write : 1'b0;
      if (d_readdatavalid) begin
        if (m_tags.size() == 0) m_err = 1'b1;
        else void'(m_tags.pop_front());
      end
      if (g >= 0 && rd && !d_waitrequest) m_tags.push_back(g[0]);
      if (g >= 0) begin
        if (m_owner < 0) begin
          if (d_waitrequest) m_owner = g;
          else m_last = g[0];
        end else if (!(rd || wr)) m_owner = -1;
        else if (!d_waitrequest) begin
          m_last  = g[0];
          m_owner = -1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    {r0_read, r0_write, r1_read, r1_write} = '0;
    r0_address = '0; r1_address = '0;
    r0_byteenable = 4'hF; r1_byteenable = 4'hF;
    r0_writedata = '0; r1_writedata = '0;
    d_waitrequest = 1'b0; d_readdatavalid = 1'b0; d_readdata = '0; d_endofpacket = 1'b0;
  endtask

  task automatic test_reset();
    clr();
    r0_read = 1'b1; r1_write = 1'b1; d_readdatavalid = 1'b1;
    @(negedge clk);
    checks++;
    if ({d_read, d_write, r0_waitrequest, r1_waitrequest, r0_readdatavalid, r1_readdatavalid, rsp_error} !== 7'b0011000) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0011000", {d_read, d_write, r0_waitrequest, r1_waitrequest, r0_readdatavalid, r1_readdatavalid, rsp_error});
    end
    clr();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    r0_write = 1'b1; r0_address = 23'h10; r0_writedata = 32'hA;
    r1_write = 1'b1; r1_address = 23'h20; r1_writedata = 32'hB;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (d_write !== 1'b1 || d_address !== ((i % 2) ? 23'h20 : 23'h10) || r0_waitrequest !== 1'(i % 2)) begin
        failures++;
        $display("FAIL round_robin[%0d] got write=%b addr=%h r0_wait=%b exp write=1 addr=%h r0_wait=%0d",
                 i, d_write, d_address, r0_waitrequest, (i % 2) ? 23'h20 : 23'h10, i % 2);
      end
      tick();
    end
    clr();
  endtask

  task automatic test_lock();
    r0_write = 1'b1; r0_address = 23'h30;
    @(negedge clk);
    checks++;
    if (d_write !== 1'b1 || d_address !== 23'h30) begin
      failures++;
      $display("FAIL lock_prep got write=%b addr=%h exp write=1 addr=000030", d_write, d_address);
    end
    tick();
    r0_address = 23'h31; r1_write = 1'b1; r1_address = 23'h41;
    for (int i = 0; i < 4; i++) begin
      d_waitrequest = (i < 3);
      @(negedge clk);
      checks++;
      if (d_address !== 23'h41 || d_write !== 1'b1 || r0_waitrequest !== 1'b1 || r1_waitrequest !== 1'(i < 3)) begin
        failures++;
        $display("FAIL lock_hold[%0d] got addr=%h write=%b r0_wait=%b r1_wait=%b exp addr=000041 write=1 r0_wait=1 r1_wait=%0d",
                 i, d_address, d_write, r0_waitrequest, r1_waitrequest, i < 3);
      end
      tick();
    end
    r1_write = 1'b0;
    @(negedge clk);
    checks++;
    if (d_address !== 23'h31 || d_write !== 1'b1 || r0_waitrequest !== 1'b0) begin
      failures++;
      $display("FAIL lock_release got addr=%h write=%b r0_wait=%b exp addr=000031 write=1 r0_wait=0", d_address, d_write, r0_waitrequest);
    end
    tick();
    clr();
  endtask

  task automatic test_read_order();
    bit ids [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      clr();
      if (ids[i]) r1_read = 1'b1; else r0_read = 1'b1;
      r0_address = 23'h100 + 23'(i); r1_address = 23'h100 + 23'(i);
      tick();
    end
    clr();
    for (int i = 0; i < 4; i++) begin
      d_readdatavalid = 1'b1; d_readdata = 32'hA0 + 32'(i); d_endofpacket = (i == 3);
      @(negedge clk);
      checks++;
      if ({r0_readdatavalid, r1_readdatavalid} !== (ids[i] ? 2'b01 : 2'b10) ||
          (ids[i] ? r1_readdata : r0_readdata) !== 32'hA0 + 32'(i) ||
          (r0_endofpacket | r1_endofpacket) !== 1'(i == 3)) begin
        failures++;
        $display("FAIL read_order[%0d] got rdv=%b data=%h eop=%b exp rdv=%b data=%h eop=%0d", i,
                 {r0_readdatavalid, r1_readdatavalid}, ids[i] ? r1_readdata : r0_readdata,
                 r0_endofpacket | r1_endofpacket, ids[i] ? 2'b01 : 2'b10, 32'hA0 + 32'(i), i == 3);
      end
      tick();
    end
    clr();
  endtask

  task automatic test_full();
    r0_read = 1'b1;
    for (int i = 0; i < 16; i++) begin
      r0_address = 23'(i);
      tick();
    end
    d_readdatavalid = 1'b1;
    @(negedge clk);
    checks++;
    if (r0_waitrequest !== 1'b1 || d_read !== 1'b0 || r0_readdatavalid !== 1'b1) begin
      failures++;
      $display("FAIL full_block got r0_wait=%b d_read=%b rdv=%b exp r0_wait=1 d_read=0 rdv=1", r0_waitrequest, d_read, r0_readdatavalid);
    end
    tick();
    d_readdatavalid = 1'b0;
    @(negedge clk);
    checks++;
    if (r0_waitrequest !== 1'b0 || d_read !== 1'b1) begin
      failures++;
      $display("FAIL full_unblock got r0_wait=%b d_read=%b exp r0_wait=0 d_read=1", r0_waitrequest, d_read);
    end
    tick();
    r0_read = 1'b0;
    for (int i = 0; i < 16; i++) begin
      d_readdatavalid = 1'b1;
      @(negedge clk);
      checks++;
      if (r0_readdatavalid !== 1'b1 || r1_readdatavalid !== 1'b0) begin
        failures++;
        $display("FAIL full_drain[%0d] got rdv0=%b rdv1=%b exp rdv0=1 rdv1=0", i, r0_readdatavalid, r1_readdatavalid);
      end
      tick();
    end
    clr();
  endtask

  task automatic test_orphan();
    d_readdatavalid = 1'b1;
    @(negedge clk);
    checks++;
    if ({r0_readdatavalid, r1_readdatavalid, rsp_error} !== 3'b000) begin
      failures++;
      $display("FAIL orphan_valid got rdv=%b err=%b exp rdv=00 err=0", {r0_readdatavalid, r1_readdatavalid}, rsp_error);
    end
    tick();
    d_readdatavalid = 1'b0;
    tick();
    tick();
    checks++;
    if (rsp_error !== 1'b1) begin
      failures++;
      $display("FAIL orphan_sticky got err=%b exp err=1", rsp_error);
    end
    reset = 1'b1;
    #2;
    checks++;
    if (rsp_error !== 1'b0) begin
      failures++;
      $display("FAIL orphan_reset got err=%b exp err=0", rsp_error);
    end
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset_lock();
    r0_read = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    r0_read = 1'b0; r0_write = 1'b1; r0_address = 23'h55; d_waitrequest = 1'b1;
    tick();
    r1_write = 1'b1; r1_address = 23'h66;
    #1;
    checks++;
    if (d_write !== 1'b1 || d_address !== 23'h55 || r1_waitrequest !== 1'b1) begin
      failures++;
      $display("FAIL lock0_hold got write=%b addr=%h r1_wait=%b exp write=1 addr=000055 r1_wait=1", d_write, d_address, r1_waitrequest);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({d_read, d_write, r0_waitrequest, r1_waitrequest} !== 4'b0011) begin
      failures++;
      $display("FAIL reset_in_lock got %b exp 0011", {d_read, d_write, r0_waitrequest, r1_waitrequest});
    end
    @(negedge clk);
    reset = 1'b0;
    d_waitrequest = 1'b0; r0_address = 23'h60; r1_address = 23'h70;
    #1;
    checks++;
    if (d_write !== 1'b1 || d_address !== 23'h60) begin
      failures++;
      $display("FAIL post_reset_first got write=%b addr=%h exp write=1 addr=000060", d_write, d_address);
    end
    tick();
    checks++;
    if (d_write !== 1'b1 || d_address !== 23'h70) begin
      failures++;
      $display("FAIL post_reset_second got write=%b addr=%h exp write=1 addr=000070", d_write, d_address);
    end
    tick();
    clr();
    d_readdatavalid = 1'b1;
    #1;
    checks++;
    if ({r0_readdatavalid, r1_readdatavalid} !== 2'b00) begin
      failures++;
      $display("FAIL post_reset_tags got rdv=%b exp 00", {r0_readdatavalid, r1_readdatavalid});
    end
    tick();
    checks++;
    if (rsp_error !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_empty got err=%b exp 1", rsp_error);
    end
    clr();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_random();
    bit h0, h1;
    int op, g;
    logic [8:0] ev;
    h0 = 1'b0; h1 = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!h0) begin
        op = int'($urandom % 4);
        r0_read = (op == 1 || op == 3); r0_write = (op == 2);
        r0_address = 23'($urandom); r0_byteenable = 4'($urandom); r0_writedata = $urandom;
      end
      if (!h1) begin
        op = int'($urandom % 4);
        r1_read = (op == 1 || op == 3); r1_write = (op == 2);
        r1_address = 23'($urandom); r1_byteenable = 4'($urandom); r1_writedata = $urandom;
      end
      d_waitrequest = ($urandom % 4 == 0);
      d_readdatavalid = (m_tags.size() > 0) ? ($urandom % 3 == 0) : ($urandom % 300 == 0);
      d_readdata = $urandom;
      d_endofpacket = 1'($urandom);
      @(negedge clk);
      ev = exp_vec();
      g = exp_gnt();
      checks++;
      if (dut_vec !== ev) begin
        failures++;
        $display("FAIL random_ctrl[%0d] got=%b exp=%b", c, dut_vec, ev);
      end
      if (g >= 0) begin
        checks++;
        if ({d_address, d_byteenable, d_writedata} !== (g == 1 ? {r1_address, r1_byteenable, r1_writedata}
                                                                : {r0_address, r0_byteenable, r0_writedata})) begin
          failures++;
          $display("FAIL random_mux[%0d] got addr=%h be=%h wd=%h for requester %0d", c, d_address, d_byteenable, d_writedata, g);
        end
      end
      if (d_readdatavalid) begin
        checks++;
        if (r0_readdata !== d_readdata || r1_readdata !== d_readdata) begin
          failures++;
          $display("FAIL random_rdata[%0d] got %h/%h exp %h", c, r0_readdata, r1_readdata, d_readdata);
        end
      end
      h0 = (r0_read || r0_write) && r0_waitrequest;
      h1 = (r1_read || r1_write) && r1_waitrequest;
      tick();
    end
    clr();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_lock();
    test_read_order();
    test_full();
    test_orphan();
    test_reset_lock();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tse_ddr_bridge_arbiter.md
Name: tse_ddr_bridge_arbiter

Overview:
- Shares the single Avalon-MM slave port of the TSE-to-DDR clock bridge between two requesters on the slave-clock side: r0 is the TSE SGDMA receive-write master and r1 is the transmit-read master.
- Arbitration is round-robin, one word at a time, with the grant locked while the downstream port holds waitrequest.
- Read responses come back in order; a tag FIFO records which requester issued each read and steers each readdatavalid back to it.

Parameters:
ADDR_W, 23, word address width
DATA_W, 32, data width
BE_W, 4, byteenable width
TAG_DEPTH, 16, max outstanding reads (power of 2)
TAG_AW, 4, log2(TAG_DEPTH)

Ports:
clk  in  1  slave-side clock (bridge slave_clk)
reset  in  1  asynchronous, active-high reset
rN_address  in  ADDR_W  requester N address (N=0,1, identical port set each)
rN_byteenable  in  BE_W  requester N byteenable
rN_read  in  1  read request
rN_write  in  1  write request
rN_writedata  in  DATA_W  write data
rN_waitrequest  out  1  stall to requester N
rN_readdata  out  DATA_W  read data (broadcast)
rN_readdatavalid  out  1  read data valid for N
rN_endofpacket  out  1  endofpacket qualified by rN_readdatavalid
d_address  out  ADDR_W  to bridge slave_address
d_byteenable  out  BE_W  to bridge
d_read  out  1  to bridge
d_write  out  1  to bridge
d_writedata  out  DATA_W  to bridge
d_waitrequest  in  1  from bridge
d_readdata  in  DATA_W  from bridge
d_readdatavalid  in  1  from bridge
d_endofpacket  in  1  from bridge
rsp_error  out  1  sticky: readdatavalid arrived with no tag pending

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-high; it clears state to IDLE, last=1 (r0 wins the first contest), tag FIFO empty and rsp_error=0.
- Outputs while reset is asserted: d_read=0, d_write=0, rN_waitrequest=1, rN_readdatavalid=0.
- Request: reqN = rN_read | rN_write. A read is blocked when tag_count==TAG_DEPTH; a blocked read is not eligible for grant.
- Grant FSM states: IDLE, LOCK0, LOCK1. The grant gnt is combinational in the current cycle.
- IDLE:
  - One eligible requester: it gets gnt.
  - Both eligible: gnt = !last.
  - Neither eligible: no grant.
  - If gnt=N and d_waitrequest=1, go to LOCKN.
  - If gnt=N and d_waitrequest=0, the transfer completes this cycle; set last=N and stay in IDLE.
- LOCKN:
  - gnt=N unconditionally; the other requester is ignored.
  - On d_waitrequest=0 the transfer completes; set last=N and go to IDLE.
  - If requester N drops its request while locked (protocol violation), go to IDLE. No assertion is required in RTL.
- Datapath mux: d_* = fields of the granted requester, with zero-cycle latency. With no grant, d_read=d_write=0 and the other fields are don't-care (drive r0 fields).
- Waitrequest:
  - Granted requester: rN_waitrequest = d_waitrequest.
  - Any other requester: rN_waitrequest = 1.
- Completion: an accept is d_read|d_write with d_waitrequest=0. Throughput is one accept per cycle; back-to-back alternation is allowed with no bubble.
- Tag FIFO:
  - Width 1, stores the requester id.
  - Push on an accepted read.
  - Pop on d_readdatavalid when not empty.
  - Simultaneous push and pop: count unchanged, both take effect.
  - The full check uses the registered count, so a pop in the same cycle does not unblock a read.
  - Pointers wrap modulo TAG_DEPTH.
- Response routing:
  - rN_readdatavalid = d_readdatavalid & !empty & (head==N).
  - readdata is broadcast to both requesters.
  - rN_endofpacket = d_endofpacket & rN_readdatavalid.
- Orphan response: d_readdatavalid while the FIFO is empty sets rsp_error (cleared only by reset). No requester sees valid for it.
- Writes: never touch the tag FIFO.
- Reset mid-operation: all pending tags are discarded. This block and the bridge share the slave-side reset, so no stale responses follow.

Decomposition:
- Shared package tse_ddr_bridge_pkg holds:
  - localparams for FSM state encoding (IDLE=2'd0, LOCK0=2'd1, LOCK1=2'd2);
  - requester id constants RID_TSE_RX=1'b0, RID_TSE_TX=1'b1.
- One sub-module: tse_ddr_bridge_tag_fifo. It is a synchronous register FIFO, width 1, depth TAG_DEPTH, with full, empty and count outputs.
- The arbiter FSM and the mux live in the top module.

Test Plan:
- Both request writes continuously, d_waitrequest=0 → accepts alternate r0,r1,r0,r1 in four consecutive cycles, no bubble; the first winner is r0.
- r1 write granted in IDLE with d_waitrequest=1 for 3 cycles while r0 requests → d_* holds r1 fields for 4 cycles and r0_waitrequest=1 throughout; r0 is accepted in the cycle after r1 completes.
- Interleaved reads r0,r1,r1,r0, then the bridge returns 4 readdatavalids with data 0xA0..0xA3 → readdatavalid asserts on r0,r1,r1,r0 in order, with matching data.
- r0 issues 16 reads with no responses returned → 17th read sees r0_waitrequest=1 and d_read=0; a pop in the same cycle does not accept it; the read is accepted the next cycle.
- d_readdatavalid with an empty FIFO → rsp_error=1 and stays high; neither rN_readdatavalid asserts; reset clears rsp_error.
- Reset asserted in LOCK0 with 5 tags pending → immediately d_read=d_write=0, both waitrequests=1; after release the FSM is in IDLE, the tag count is 0 and r0 wins the first contest.
